control_unit: RTL and testbench

- Main control decoder for the single-issue RV32I datapath.
- Maps the 7-bit instruction opcode to the datapath control strobes and the 2-bit ALUOp consumed by the ALU-control block.
- Outputs are registered: one clock of latency from opcode to controls, with synchronous clearing on reset.
- Sits between the instruction fetch/decode stage and the register file, ALU and data-memory muxes.

---
 rtl/control_pkg.sv | 30 +++
 rtl/main_decoder.sv | 44 ++++
 rtl/control_unit.sv | 43 ++++
 tb/tb_control_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared opcode/ALUOp constants and the control-word type
package control_pkg;

    localparam int OPCODE_W = 7;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

    // Field order matches the datapath's pipeline registers; all-zero is the reset/bubble word.
    typedef struct packed {
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_word_t;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational opcode to control-word decode
module main_decoder
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_word_t          ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_R;
            end
            OP_LOAD: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALUOP_BR;
            end
            OP_IMM: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALUOP_I;
            end
            // Unsupported opcodes, X/Z included, become a harmless bubble flagged illegal.
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - registered RV32I main control decoder
module control_unit
    import control_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                ALUSrc,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Illegal
);

    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;

    main_decoder u_main_decoder (
        .opcode_i (opcode),
        .ctrl_o   (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUSrc   = ctrl_q.alu_src;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.alu_op;
    assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Illegal;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    // {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal}
    logic [8:0] obs;
    assign obs = {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal};

    localparam logic [8:0] W_ZERO   = 9'b000000000;
    localparam logic [8:0] W_RTYPE  = 9'b001000100;
    localparam logic [8:0] W_LOAD   = 9'b111100000;
    localparam logic [8:0] W_STORE  = 9'b100010000;
    localparam logic [8:0] W_BRANCH = 9'b000001010;
    localparam logic [8:0] W_IMM    = 9'b101000110;
    localparam logic [8:0] W_ILL    = 9'b000000001;

    control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .ALUSrc   (ALUSrc),
        .MemToReg (MemToReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if ((MemRead & MemWrite) !== 1'b0) begin
                errors++;
                $display("FAIL inv_rd_wr MemRead=%b MemWrite=%b required not both 1", MemRead, MemWrite);
            end
            checks++;
            if ((RegWrite & (MemWrite | Branch)) !== 1'b0) begin
                errors++;
                $display("FAIL inv_regwrite RegWrite=%b MemWrite=%b Branch=%b required exclusive", RegWrite, MemWrite, Branch);
            end
            checks++;
            if ((MemToReg & ~MemRead) !== 1'b0) begin
                errors++;
                $display("FAIL inv_memtoreg MemToReg=%b MemRead=%b required MemToReg implies MemRead", MemToReg, MemRead);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        opcode = 7'b0110011;
        step();
        step();
        inv_en = 1'b1;
        checks++;
        if (obs !== W_ZERO) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, W_ZERO);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== W_RTYPE) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs, W_RTYPE);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] ops [4];
        logic [8:0] exp [4];
        ops[0] = 7'b0110011; exp[0] = W_RTYPE;
        ops[1] = 7'b0100011; exp[1] = W_STORE;
        ops[2] = 7'b0000011; exp[2] = W_LOAD;
        ops[3] = 7'b1100011; exp[3] = W_BRANCH;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL seq_%0d opcode=%b got=%b exp=%b", i, ops[i], obs, exp[i]);
            end
        end
    endtask

    task automatic test_latency();
        opcode = 7'b0000011;
        step();
        checks++;
        if (obs !== W_LOAD) begin
            errors++;
            $display("FAIL latency_load got=%b exp=%b", obs, W_LOAD);
        end
        #2 opcode = 7'b1100011;
        #1;
        checks++;
        if (obs !== W_LOAD) begin
            errors++;
            $display("FAIL latency_hold got=%b exp=%b", obs, W_LOAD);
        end
        step();
        checks++;
        if (obs !== W_BRANCH) begin
            errors++;
            $display("FAIL latency_switch got=%b exp=%b", obs, W_BRANCH);
        end
    endtask

    task automatic test_itype();
        opcode = 7'b0010011;
        step();
        checks++;
        if (obs !== W_IMM) begin
            errors++;
            $display("FAIL itype got=%b exp=%b", obs, W_IMM);
        end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3];
        ops[0] = 7'b0000000;
        ops[1] = 7'b1111111;
        ops[2] = 7'b0110001;
        for (int i = 0; i < 3; i++) begin
            opcode = ops[i];
            step();
            checks++;
            if (obs !== W_ILL) begin
                errors++;
                $display("FAIL illegal_%0d opcode=%b got=%b exp=%b", i, ops[i], obs, W_ILL);
            end
        end
        opcode = 7'b0110011;
        step();
        checks++;
        if (obs !== W_RTYPE) begin
            errors++;
            $display("FAIL illegal_clear got=%b exp=%b", obs, W_RTYPE);
        end
    endtask

    task automatic test_mid_reset();
        opcode = 7'b0100011;
        step();
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre MemWrite=%b exp=1", MemWrite);
        end
        rst = 1'b1;
        step();
        checks++;
        if (obs !== W_ZERO) begin
            errors++;
            $display("FAIL midrst_clear got=%b exp=%b", obs, W_ZERO);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== W_STORE) begin
            errors++;
            $display("FAIL midrst_resume got=%b exp=%b", obs, W_STORE);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 7'b0;
        test_reset();
        test_sequence();
        test_latency();
        test_itype();
        test_illegal();
        test_mid_reset();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
